// File: rtl/uart_crc_frame_tx_if.sv
// Valid/ready byte stream feeding the UART CRC frame transmitter.
// The source side drives data, last and valid. The transmitter side returns ready.
interface uart_crc_frame_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_last;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_last, output s_valid, input s_ready);
    modport slave  (input s_data, input s_last, input s_valid, output s_ready);
endinterface

// File: rtl/uart_crc_frame_tx.sv
// UART transmitter that appends the running CRC-8 of each packet as an extra frame.
// The packet ends at the word flagged s_last. The CRC restarts after every trailer.
module uart_crc_frame_tx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         DATA_BITS    = 8,
    parameter int         PARITY       = 0,
    parameter int         STOP_BITS    = 1,
    parameter logic [7:0] CRC_POLY     = 8'h07,
    parameter logic [7:0] CRC_INIT     = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_crc_frame_tx_if.slave    s,
    output logic                  tx,
    output logic                  busy,
    output logic [7:0]            crc_out,
    output logic                  crc_valid
);
    localparam int         BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic       PAR_ODD  = (PARITY == 2);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP,
        S_CRC_START, S_CRC_DATA, S_CRC_PARITY, S_CRC_STOP
    } state_t;

    state_t               r_state, w_state_next;
    logic [BAUD_W-1:0]    r_baud, w_baud_next;
    logic [2:0]           r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_last;
    logic [7:0]           r_crc, w_crc_next;
    logic [7:0]           r_crc_tx, w_crc_tx_next;
    logic                 r_tx;
    logic [7:0]           r_crc_out;
    logic                 r_crc_valid;
    logic                 w_tick, w_accept, w_load_crc_tx, w_crc_done;

    // MSB-first CRC over one DATA_BITS-wide word
    function automatic logic [7:0] crc_step(input logic [7:0] crc_in, input logic [DATA_BITS-1:0] word);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = DATA_BITS - 1; i >= 0; i--) begin
            fb = c[7] ^ word[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
        return c;
    endfunction

    function automatic logic tx_level(input state_t st, input logic [2:0] idx,
                                      input logic [7:0] d, input logic [7:0] c);
        case (st)
            S_START, S_CRC_START: return 1'b0;
            S_DATA:               return d[idx];
            S_PARITY:             return (^d) ^ PAR_ODD;
            S_CRC_DATA:           return c[idx];
            S_CRC_PARITY:         return (^c) ^ PAR_ODD;
            default:              return 1'b1;
        endcase
    endfunction

    assign w_tick = (r_baud == BAUD_MAX);

    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = r_baud;
        w_bit_next    = r_bit;
        w_accept      = 1'b0;
        w_load_crc_tx = 1'b0;
        w_crc_done    = 1'b0;
        if (r_state != S_IDLE) begin
            w_baud_next = w_tick ? '0 : BAUD_W'(r_baud + 1'b1);
        end
        case (r_state)
            S_IDLE: begin
                if (s.s_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                    w_bit_next   = '0;
                end
            end
            S_START: if (w_tick) w_state_next = S_DATA;
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'(DATA_BITS - 1)) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_PARITY: if (w_tick) w_state_next = S_STOP;
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        w_bit_next = '0;
                        if (r_last) begin
                            w_state_next  = S_CRC_START;
                            w_load_crc_tx = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_CRC_START: if (w_tick) w_state_next = S_CRC_DATA;
            S_CRC_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = (PARITY != 0) ? S_CRC_PARITY : S_CRC_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_CRC_PARITY: if (w_tick) w_state_next = S_CRC_STOP;
            S_CRC_STOP: begin
                if (w_tick) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        w_bit_next   = '0;
                        w_crc_done   = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_data_next   = w_accept ? s.s_data : r_data;
    assign w_crc_tx_next = w_load_crc_tx ? r_crc : r_crc_tx;
    assign w_crc_next    = w_accept   ? crc_step(r_crc, s.s_data) :
                           w_crc_done ? CRC_INIT : r_crc;

    // tx is registered from the next-state view so the pin never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_crc       <= CRC_INIT;
            r_crc_tx    <= '0;
            r_tx        <= 1'b1;
            r_crc_out   <= 8'h00;
            r_crc_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_baud      <= w_baud_next;
            r_bit       <= w_bit_next;
            r_data      <= w_data_next;
            r_last      <= w_accept ? s.s_last : r_last;
            r_crc       <= w_crc_next;
            r_crc_tx    <= w_crc_tx_next;
            r_tx        <= tx_level(w_state_next, w_bit_next, 8'(w_data_next), w_crc_tx_next);
            r_crc_out   <= w_crc_done ? r_crc_tx : r_crc_out;
            r_crc_valid <= w_crc_done;
        end
    end

    assign s.s_ready = (r_state == S_IDLE) && !reset;
    assign tx        = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign crc_out   = r_crc_out;
    assign crc_valid = r_crc_valid;
endmodule

// File: tb/tb_uart_crc_frame_tx.sv
// Directed bench for uart_crc_frame_tx across three parameter sets with hand-computed frames.
// The three sets are: default 8N1; 7 data bits with even parity and 2 stop bits; odd parity at 4 clk per bit.
module tb_uart_crc_frame_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_crc_frame_tx_if #(.DATA_BITS(8)) if0 ();
    uart_crc_frame_tx_if #(.DATA_BITS(7)) if1 ();
    uart_crc_frame_tx_if #(.DATA_BITS(8)) if2 ();

    logic tx0, busy0, crc_valid0; logic [7:0] crc_out0;
    logic tx1, busy1, crc_valid1; logic [7:0] crc_out1;
    logic tx2, busy2, crc_valid2; logic [7:0] crc_out2;

    uart_crc_frame_tx u_dut0 (
        .clk(clk), .reset(reset), .s(if0.slave),
        .tx(tx0), .busy(busy0), .crc_out(crc_out0), .crc_valid(crc_valid0));

    uart_crc_frame_tx #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .s(if1.slave),
        .tx(tx1), .busy(busy1), .crc_out(crc_out1), .crc_valid(crc_valid1));

    uart_crc_frame_tx #(.CLKS_PER_BIT(4), .PARITY(2)) u_dut2 (
        .clk(clk), .reset(reset), .s(if2.slave),
        .tx(tx2), .busy(busy2), .crc_out(crc_out2), .crc_valid(crc_valid2));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic tx_m, rdy_m, cv_m; logic [7:0] co_m;
    always_comb begin
        case (sel)
            1:       begin tx_m = tx1; rdy_m = if1.s_ready; cv_m = crc_valid1; co_m = crc_out1; end
            2:       begin tx_m = tx2; rdy_m = if2.s_ready; cv_m = crc_valid2; co_m = crc_out2; end
            default: begin tx_m = tx0; rdy_m = if0.s_ready; cv_m = crc_valid0; co_m = crc_out0; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s_sel, input logic [7:0] d, input logic l, input logic v);
        case (s_sel)
            1:       begin if1.s_data = d[6:0]; if1.s_last = l; if1.s_valid = v; end
            2:       begin if2.s_data = d;      if2.s_last = l; if2.s_valid = v; end
            default: begin if0.s_data = d;      if0.s_last = l; if0.s_valid = v; end
        endcase
    endtask

    task automatic send(input int s_sel, input logic [7:0] d, input logic l);
        int t;
        t   = 0;
        sel = s_sel;
        drive(s_sel, d, l, 1'b1);
        #0;
        while (!rdy_m && t < 5000) begin @(negedge clk); t++; end
        check("send_ready", {31'd0, rdy_m}, 32'd1);
        @(posedge clk);
        #1 drive(s_sel, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (!rdy_m && cnt < 5000) begin cnt++; @(negedge clk); end
    endtask

    task automatic rx_frame(input int nbits, input int cpb, output logic [15:0] bits);
        int t;
        t    = 0;
        bits = '0;
        @(negedge clk);
        while (tx_m !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bits[i] = tx_m;
            if (i < nbits - 1) repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic wait_crc(output logic [7:0] value, output int width);
        int t;
        t     = 0;
        width = 0;
        while (!cv_m && t < 5000) begin @(negedge clk); t++; end
        value = co_m;
        while (cv_m && width < 10) begin width++; @(negedge clk); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits, b0, b1, b2;
        logic [7:0]  cval;
        int          cnt, width, pulses;

        reset = 1'b1;
        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);
        drive(2, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_tx",        {31'd0, tx0}, 32'd1);
        check("rst_ready",     {31'd0, if0.s_ready}, 32'd0);
        check("rst_busy",      {31'd0, busy0}, 32'd0);
        check("rst_crc_out",   {24'd0, crc_out0}, 32'h00);
        check("rst_crc_valid", {31'd0, crc_valid0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, if0.s_ready}, 32'd1);

        // Single-word packet 0x31 -> trailer 0x97
        send(0, 8'h31, 1'b1);
        rx_frame(10, 16, bits);
        check("t1_data_frame", {16'd0, bits}, 32'h262);
        rx_frame(10, 16, bits);
        check("t1_crc_frame", {16'd0, bits}, 32'h32E);
        wait_crc(cval, width);
        check("t1_crc_out", {24'd0, cval}, 32'h97);
        check("t1_crc_pulse_width", width, 1);

        // Two-word packet 0x01,0x02 -> 0x1B; then 0x01 alone -> 0x07
        send(0, 8'h01, 1'b0);
        wait_ready(cnt);
        check("t2_ready_low_frame", cnt, 160);
        send(0, 8'h02, 1'b1);
        wait_ready(cnt);
        check("t2_ready_low_frame_plus_crc", cnt, 320);
        wait_crc(cval, width);
        check("t2_crc_out", {24'd0, cval}, 32'h1B);
        check("t2_crc_pulse_width", width, 1);
        send(0, 8'h01, 1'b1);
        wait_crc(cval, width);
        check("t2_crc_reinit", {24'd0, cval}, 32'h07);

        // 7E2: 0x55 -> frame 0x6AA, CRC 0xAC -> frame 0xD58
        send(1, 8'h55, 1'b1);
        rx_frame(11, 16, bits);
        check("t3_data_frame", {16'd0, bits}, 32'h6AA);
        rx_frame(12, 16, bits);
        check("t3_crc_frame", {16'd0, bits}, 32'hD58);
        wait_crc(cval, width);
        check("t3_crc_out", {24'd0, cval}, 32'hAC);

        // Odd parity, 4 clk/bit: start + 8 zero bits low for exactly 36 clk
        send(2, 8'h00, 1'b1);
        cnt = 0;
        @(negedge clk);
        while (!tx_m && cnt < 100) begin cnt++; @(negedge clk); end
        check("t4_low_run", cnt, 36);
        rx_frame(11, 4, bits);
        check("t4_crc_frame", {16'd0, bits}, 32'h600);
        wait_crc(cval, width);
        check("t4_crc_pulse_width", width, 1);

        // Reset during data bit 3 of a non-final 0x31
        send(0, 8'h31, 1'b0);
        repeat (69) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_tx_async", {31'd0, tx0}, 32'd1);
        check("t5_busy", {31'd0, busy0}, 32'd0);
        check("t5_ready_in_reset", {31'd0, if0.s_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (crc_valid0) pulses++;
        end
        check("t5_no_crc_pulse", pulses, 0);
        send(0, 8'h31, 1'b1);
        wait_crc(cval, width);
        check("t5_crc_after_reset", {24'd0, cval}, 32'h97);

        // s_valid held with data changing every cycle: accepts land on cycles 0, 45, 90
        sel = 2;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    drive(2, 8'(k), 1'b0, 1'b1);
                    @(negedge clk);
                end
                drive(2, 8'h00, 1'b0, 1'b0);
            end
            begin
                rx_frame(11, 4, b0);
                rx_frame(11, 4, b1);
                rx_frame(11, 4, b2);
            end
        join
        check("t6_word0", {16'd0, b0}, 32'h600);
        check("t6_word1", {16'd0, b1}, 32'h65A);
        check("t6_word2", {16'd0, b2}, 32'h6B4);
        repeat (10) @(negedge clk);
        check("t6_no_extra_word", {31'd0, busy2}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
